pi_gpio_ctrl: RTL and testbench

//  Register-mapped controller for the 28-pin Pi accelerator GPIO header.

---
 rtl/pi_gpio_ctrl.sv | 119 +++++++++++
 tb/tb_pi_gpio_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pi_gpio_ctrl.sv
// Byte-addressed GPIO controller for the 28-pin Pi header: OE/DATA/STAT/IEN banks,
// input synchroniser, primed change detection and a level interrupt.
module pi_gpio_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_OE      = 8'h90,
  parameter logic [7:0] REG_DATA    = 8'h98,
  parameter logic [7:0] REG_STAT    = 8'hA0,
  parameter logic [7:0] REG_IEN     = 8'hA4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nr_wr_en,
  input  logic [7:0]  nr_wr_reg,
  input  logic [7:0]  nr_wr_dat,
  input  logic [7:0]  nr_rd_reg,
  output logic [7:0]  nr_rd_dat,
  output logic [27:0] gpio_o,
  output logic [27:0] gpio_t,
  input  logic [27:0] gpio_i,
  output logic        irq
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [27:0] oe_q, oe_d;
  logic [27:0] out_q, out_d;
  logic [27:0] stat_q, stat_d;
  logic [27:0] ien_q, ien_d;
  logic [27:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][27:0] sync_q, sync_d;
  logic [2:0]  prime_q, prime_d;
  logic [7:0]  rd_dat_q, rd_dat_d;

  logic [31:0] wr_mask, wr_data;
  logic [27:0] sync_last, chg, stat_clr;
  logic        wr_oe, wr_dat, wr_stat, wr_ien;

  // Bits 31:28 of the 32-bit byte view do not exist and are dropped here.
  function automatic logic [27:0] merge_byte(input logic [27:0] cur,
                                             input logic [31:0] mask,
                                             input logic [31:0] data);
    logic [31:0] r;
    r = ({4'h0, cur} & ~mask) | data;
    return r[27:0];
  endfunction

  function automatic logic [7:0] pick_byte(input logic [27:0] bank, input logic [1:0] idx);
    logic [31:0] r;
    r = {4'h0, bank} >> {idx, 3'b000};
    return r[7:0];
  endfunction

  assign sync_last = sync_q[SYNC_STAGES-1];
  // Change detection is held off until the synchroniser has filled after reset.
  assign chg = (prime_q == PRIME_MAX) ? (sync_last ^ prev_q) : 28'h0;

  always_comb begin
    wr_mask  = 32'hFF << {nr_wr_reg[1:0], 3'b000};
    wr_data  = {4{nr_wr_dat}} & wr_mask;
    wr_oe    = nr_wr_en && (nr_wr_reg[7:2] == REG_OE[7:2]);
    wr_dat   = nr_wr_en && (nr_wr_reg[7:2] == REG_DATA[7:2]);
    wr_stat  = nr_wr_en && (nr_wr_reg[7:2] == REG_STAT[7:2]);
    wr_ien   = nr_wr_en && (nr_wr_reg[7:2] == REG_IEN[7:2]);
    stat_clr = wr_stat ? wr_data[27:0] : 28'h0;

    oe_d   = wr_oe  ? merge_byte(oe_q,  wr_mask, wr_data) : oe_q;
    out_d  = wr_dat ? merge_byte(out_q, wr_mask, wr_data) : out_q;
    ien_d  = wr_ien ? merge_byte(ien_q, wr_mask, wr_data) : ien_q;
    // A new change in the same cycle as a clear keeps the bit set.
    stat_d = (stat_q & ~stat_clr) | chg;

    prev_d  = sync_last;
    prime_d = (prime_q == PRIME_MAX) ? prime_q : prime_q + 3'd1;

    sync_d    = sync_q;
    sync_d[0] = gpio_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end

    rd_dat_d = 8'h00;
    if (nr_rd_reg[7:2] == REG_OE[7:2])
      rd_dat_d = pick_byte(oe_q, nr_rd_reg[1:0]);
    else if (nr_rd_reg[7:2] == REG_DATA[7:2])
      rd_dat_d = pick_byte(sync_last, nr_rd_reg[1:0]);
    else if (nr_rd_reg[7:2] == REG_STAT[7:2])
      rd_dat_d = pick_byte(stat_q, nr_rd_reg[1:0]);
    else if (nr_rd_reg[7:2] == REG_IEN[7:2])
      rd_dat_d = pick_byte(ien_q, nr_rd_reg[1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_q     <= '0;
      out_q    <= '0;
      stat_q   <= '0;
      ien_q    <= '0;
      prev_q   <= '0;
      sync_q   <= '0;
      prime_q  <= '0;
      rd_dat_q <= '0;
    end else begin
      oe_q     <= oe_d;
      out_q    <= out_d;
      stat_q   <= stat_d;
      ien_q    <= ien_d;
      prev_q   <= prev_d;
      sync_q   <= sync_d;
      prime_q  <= prime_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  assign gpio_o    = out_q;
  assign gpio_t    = ~oe_q;
  assign irq       = |(stat_q & ien_q);
  assign nr_rd_dat = rd_dat_q;

endmodule

// File: tb/tb_pi_gpio_ctrl.sv
// Directed bench for pi_gpio_ctrl: register access, synchroniser latency,
// change/interrupt timing, clear-vs-set collision and mid-operation reset.
module tb_pi_gpio_ctrl;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        nr_wr_en;
  logic [7:0]  nr_wr_reg, nr_wr_dat, nr_rd_reg, nr_rd_dat;
  logic [27:0] gpio_o, gpio_t, gpio_i;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [27:0] pat;

  pi_gpio_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset),
    .nr_wr_en(nr_wr_en), .nr_wr_reg(nr_wr_reg), .nr_wr_dat(nr_wr_dat),
    .nr_rd_reg(nr_rd_reg), .nr_rd_dat(nr_rd_dat),
    .gpio_o(gpio_o), .gpio_t(gpio_t), .gpio_i(gpio_i), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] d);
    nr_wr_en  = 1'b1;
    nr_wr_reg = r;
    nr_wr_dat = d;
    tick();
    nr_wr_en  = 1'b0;
  endtask

  // Expected read data is queued when the address is presented, popped when it appears.
  task automatic rd(input string tag, input logic [7:0] r, input logic [7:0] e);
    nr_rd_reg = r;
    exp_q.push_back({24'h0, e});
    tick();
    check(tag, {24'h0, nr_rd_dat}, exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b1; nr_wr_en = 1'b0; nr_wr_reg = 8'h00; nr_wr_dat = 8'h00;
    nr_rd_reg = 8'h98; gpio_i = 28'hFFFFFFF;
    tick(); tick();
    check("rst_gpio_t", {4'h0, gpio_t}, 32'h0FFFFFFF);
    check("rst_gpio_o", {4'h0, gpio_o}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rd_dat", {24'h0, nr_rd_dat}, 32'h0);

    // Static-high pins across priming must not set STAT, even with all IEN bits on.
    reset = 1'b0;
    wr(8'hA4, 8'hFF); wr(8'hA5, 8'hFF); wr(8'hA6, 8'hFF); wr(8'hA7, 8'hFF);
    for (int i = 0; i < 20; i++) check("prime_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    check("prime_irq_late", {31'h0, irq}, 32'h0);
    rd("stat0_prime", 8'hA0, 8'h00);
    rd("stat3_prime", 8'hA3, 8'h00);
    rd("ien3_mask", 8'hA7, 8'h0F);
    wr(8'hA4, 8'h00); wr(8'hA5, 8'h00); wr(8'hA6, 8'h02); wr(8'hA7, 8'h00);

    // OE / DATA writes and synchronised input readback.
    wr(8'h90, 8'h0F);
    wr(8'h98, 8'h05);
    check("oe_gpio_t", {4'h0, gpio_t}, 32'h0FFFFFF0);
    check("dat_gpio_o", {4'h0, gpio_o}, 32'h00000005);
    pat = 28'($urandom) | 28'h0020000;
    gpio_i = pat;
    for (int i = 0; i < S + 2; i++) tick();
    rd("din_b0", 8'h98, pat[7:0]);
    rd("din_b1", 8'h99, pat[15:8]);
    rd("din_b2", 8'h9A, pat[23:16]);
    check("irq_pin17_static", {31'h0, irq}, 32'h0);
    wr(8'hA0, 8'hFF); wr(8'hA1, 8'hFF); wr(8'hA2, 8'hFF); wr(8'hA3, 8'hFF);
    rd("stat0_clr", 8'hA0, 8'h00);
    rd("stat2_clr", 8'hA2, 8'h00);

    // Top byte: bits 31:28 absent.
    wr(8'h9B, 8'hFF);
    check("top_gpio_o", {4'h0, gpio_o}, 32'h0F000005);
    rd("din_b3", 8'h9B, {4'h0, pat[27:24]});
    wr(8'h93, 8'hFF);
    check("top_gpio_t", {4'h0, gpio_t}, 32'h00FFFFF0);
    rd("oe_b3", 8'h93, 8'h0F);
    rd("oe_b0", 8'h90, 8'h0F);

    // Unmapped accesses.
    wr(8'h94, 8'hFF);
    wr(8'h9C, 8'hFF);
    check("unmap_gpio_o", {4'h0, gpio_o}, 32'h0F000005);
    check("unmap_gpio_t", {4'h0, gpio_t}, 32'h00FFFFF0);
    rd("unmap_rd_94", 8'h94, 8'h00);
    rd("unmap_rd_50", 8'h50, 8'h00);

    // Toggle pin 17: irq exactly S+1 edges later, clear drops it next cycle.
    gpio_i[17] = 1'b0;
    for (int i = 0; i < S; i++) begin
      tick();
      check("irq_before", {31'h0, irq}, 32'h0);
    end
    tick();
    check("irq_rise", {31'h0, irq}, 32'h1);
    rd("stat2_set", 8'hA2, 8'h02);
    rd("stat1_quiet", 8'hA1, 8'h00);
    wr(8'hA2, 8'h02);
    check("irq_clr", {31'h0, irq}, 32'h0);
    rd("stat2_cleared", 8'hA2, 8'h00);

    // Clear lands on the same edge as a new change: set wins.
    gpio_i[17] = 1'b1;
    for (int i = 0; i < S; i++) begin
      tick();
      check("coll_before", {31'h0, irq}, 32'h0);
    end
    wr(8'hA2, 8'h02);
    check("coll_irq", {31'h0, irq}, 32'h1);
    rd("coll_stat2", 8'hA2, 8'h02);

    // Reset in the middle of a toggle sequence.
    gpio_i[17] = 1'b0;
    nr_rd_reg = 8'hA2;
    tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check("mid_rst_gpio_t", {4'h0, gpio_t}, 32'h0FFFFFFF);
    check("mid_rst_gpio_o", {4'h0, gpio_o}, 32'h0);
    check("mid_rst_rd", {24'h0, nr_rd_dat}, 32'h0);
    nr_wr_en = 1'b1; nr_wr_reg = 8'h90; nr_wr_dat = 8'hFF;
    tick(); tick();
    check("rst_no_write", {4'h0, gpio_t}, 32'h0FFFFFFF);
    nr_wr_en = 1'b0;
    reset = 1'b0;
    wr(8'hA6, 8'h02);
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_irq", {31'h0, irq}, 32'h0);
    rd("post_rst_stat2", 8'hA2, 8'h00);
    gpio_i[17] = 1'b1;
    for (int i = 0; i < S; i++) tick();
    check("fresh_before", {31'h0, irq}, 32'h0);
    tick();
    check("fresh_irq", {31'h0, irq}, 32'h1);
    rd("fresh_stat2", 8'hA2, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
